// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the three-way (or two-way) memory arbiter.
// MEM_ARB_DBG_PORT_EN adds the debug requester to the round-robin ring.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_D = 2'd0,
    REQ_I = 2'd1,
    REQ_G = 2'd2
  } req_idx_e;

  // Pending/grant vectors always carry a slot for every requester kind.
  localparam int REQ_SLOTS = 3;

`ifdef MEM_ARB_DBG_PORT_EN
  localparam int       NUM_REQ     = 3;
  localparam req_idx_e RR_LAST_RST = REQ_G;
`else
  localparam int       NUM_REQ     = 2;
  localparam req_idx_e RR_LAST_RST = REQ_I;
`endif

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: the search begins at the requester just
// after i_last and returns the first pending one as one-hot plus an index.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = NUM_REQ
) (
  input  logic [REQ_SLOTS-1:0] i_pend,
  input  logic [1:0]           i_last,
  output logic [REQ_SLOTS-1:0] o_grant,
  output logic [1:0]           o_idx
);

  logic [1:0] w_cand;
  logic       w_found;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    o_grant = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_cand = 2'((int'(i_last) + k) % N);
      if (!w_found && i_pend[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide memory between fetch, data and (with
// MEM_ARB_DBG_PORT_EN) debug requesters; a grant is held for a whole transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [2*DATA_W-1:0] i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
`ifdef MEM_ARB_DBG_PORT_EN
  input  logic                g_req,
  input  logic                g_we,
  input  logic [ADDR_W-1:0]   g_addr,
  input  logic [DATA_W-1:0]   g_wdata,
  output logic                g_ack,
  output logic [DATA_W-1:0]   g_rdata,
`endif
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e              r_state;
  req_idx_e                r_win;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_we;
  logic [DATA_W-1:0]       r_wdata;
  logic [2*DATA_W-1:0]     r_i_rdata;
  logic [DATA_W-1:0]       r_d_rdata;
`ifdef MEM_ARB_DBG_PORT_EN
  logic [DATA_W-1:0]       r_g_rdata;
`endif

  logic [REQ_SLOTS-1:0]    w_pend;
  logic [REQ_SLOTS-1:0]    w_grant;
  logic [1:0]              w_idx;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic                    w_sel_we;
  logic [DATA_W-1:0]       w_sel_wdata;

`ifdef MEM_ARB_DBG_PORT_EN
  assign w_pend = {g_req, i_req, d_req};
`else
  assign w_pend = {1'b0, i_req, d_req};
`endif

  // r_win doubles as the round-robin pointer: it always names the last winner.
  mem_arb_rr_pick #(.N(NUM_REQ)) u_pick (
    .i_pend  (w_pend),
    .i_last  (r_win),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_we    = 1'b0;
    w_sel_wdata = '0;
    if (w_grant[REQ_D]) begin
      w_sel_addr  = d_addr;
      w_sel_we    = d_we;
      w_sel_wdata = d_wdata;
    end
    if (w_grant[REQ_I]) begin
      w_sel_addr = i_addr;
    end
`ifdef MEM_ARB_DBG_PORT_EN
    if (w_grant[REQ_G]) begin
      w_sel_addr  = g_addr;
      w_sel_we    = g_we;
      w_sel_wdata = g_wdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking throughout so every register sees pre-edge values of the others.
    if (reset) begin
      r_state   <= IDLE;
      r_win     <= RR_LAST_RST;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
`ifdef MEM_ARB_DBG_PORT_EN
      r_g_rdata <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_win   <= req_idx_e'(w_idx);
            r_addr  <= w_sel_addr;
            r_we    <= w_sel_we;
            r_wdata <= w_sel_wdata;
            r_state <= BEAT0;
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (r_win == REQ_I) begin
              r_i_rdata[2*DATA_W-1:DATA_W] <= mem_rdata;
              r_state                      <= BEAT1;
            end else begin
              // Writes leave the requester's rdata at its last read value.
              if (!r_we) begin
                if (r_win == REQ_D) r_d_rdata <= mem_rdata;
`ifdef MEM_ARB_DBG_PORT_EN
                else r_g_rdata <= mem_rdata;
`endif
              end
              r_state <= DONE;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            r_i_rdata[DATA_W-1:0] <= mem_rdata;
            r_state               <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req   = (r_state == BEAT0) || (r_state == BEAT1);
  assign mem_addr  = (r_state == BEAT1) ? r_addr + ADDR_W'(1) : r_addr;
  assign mem_we    = (r_state == BEAT1) ? 1'b0 : r_we;
  assign mem_wdata = r_wdata;

  assign i_ack   = (r_state == DONE) && (r_win == REQ_I);
  assign d_ack   = (r_state == DONE) && (r_win == REQ_D);
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
`ifdef MEM_ARB_DBG_PORT_EN
  assign g_ack   = (r_state == DONE) && (r_win == REQ_G);
  assign g_rdata = r_g_rdata;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written contention and reset-abort sequences against a byte memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack;
  logic [15:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack;
  logic [15:0] d_addr;
  logic [7:0]  d_wdata, d_rdata;
`ifdef MEM_ARB_DBG_PORT_EN
  logic        g_req, g_we, g_ack;
  logic [15:0] g_addr;
  logic [7:0]  g_wdata, g_rdata;
`endif
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  bit [7:0] mem [0:65535];
  int       mem_wait;
  int       wcnt;
  int       checks = 0;
  int       errors = 0;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
`ifdef MEM_ARB_DBG_PORT_EN
    .g_req     (g_req),
    .g_we      (g_we),
    .g_addr    (g_addr),
    .g_wdata   (g_wdata),
    .g_ack     (g_ack),
    .g_rdata   (g_rdata),
`endif
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: acks after mem_wait idle cycles of each beat.
  always @(negedge clk) begin
    if (mem_req && !reset) begin
      if (wcnt >= mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_fetch;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          wait_n;
    logic [15:0] exp_rdata;
    int          exp_ack_cyc;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input string nm);
    int          ack_cyc = -1;
    int          nacks = 0;
    int          nb = 0;
    logic [15:0] ba [2];
    logic        bw [2];
    logic [15:0] got = '0;
    logic        right = 1'b0;
    mem_wait = v.wait_n;
    tick();
    if (v.is_fetch) begin
      i_req = 1'b1; i_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mem_req && mem_ack) begin
        if (nb < 2) begin ba[nb] = mem_addr; bw[nb] = mem_we; end
        nb++;
      end
      if (d_ack || i_ack) begin
        nacks++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          right   = v.is_fetch ? i_ack : d_ack;
          got     = v.is_fetch ? i_rdata : {8'h00, d_rdata};
        end
        i_req = 1'b0;
        d_req = 1'b0;
      end
      if (ack_cyc >= 0 && c >= ack_cyc + 3) break;
    end
    check({nm, " ack_cycle"}, ack_cyc, v.exp_ack_cyc);
    check({nm, " ack_count"}, nacks, 1);
    check({nm, " ack_port"}, {31'd0, right}, 1);
    check({nm, " rdata"}, {16'd0, got}, {16'd0, v.exp_rdata});
    check({nm, " beats"}, nb, v.is_fetch ? 2 : 1);
    check({nm, " beat0_addr"}, {16'd0, ba[0]}, {16'd0, v.exp_a0});
    check({nm, " beat0_we"}, {31'd0, bw[0]}, {31'd0, v.we});
    if (v.is_fetch) begin
      check({nm, " beat1_addr"}, {16'd0, ba[1]}, {16'd0, v.exp_a1});
      check({nm, " beat1_we"}, {31'd0, bw[1]}, 0);
    end
  endtask

`ifdef MEM_ARB_DBG_PORT_EN
  localparam int N_ORDER = 6;
  int exp_order [N_ORDER] = '{0, 1, 2, 0, 1, 2};
`else
  localparam int N_ORDER = 4;
  int exp_order [N_ORDER] = '{0, 1, 0, 1};
`endif

  initial begin
    int got_order [N_ORDER];
    int n_got, multi, bad_ack, nacks, ack_cyc;
    logic d_drop, i_drop;
    logic [15:0] got16;
`ifdef MEM_ARB_DBG_PORT_EN
    logic g_drop;
    g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
`endif
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_wait = 0; wcnt = 0;
    mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h34;
    mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
    mem[16'h0100] = 8'h5E;
    mem[16'h0200] = 8'h9C; mem[16'h0201] = 8'h07;
    mem[16'h0300] = 8'h11; mem[16'h0301] = 8'h22;
    mem[16'h0050] = 8'h77; mem[16'h0060] = 8'h88;

    //          fetch we    addr      wd     wait rdata     ackc a0        a1
    vecs[0] = '{1'b0, 1'b1, 16'h0040, 8'h3A, 1,   16'h0000, 3,   16'h0040, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 8'h00, 0,   16'h1234, 3,   16'h0010, 16'h0011};
    vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 0,   16'hABCD, 3,   16'hFFFF, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 16'h0040, 8'h00, 0,   16'h003A, 2,   16'h0040, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 16'h0100, 8'h00, 2,   16'h005E, 4,   16'h0100, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'h0200, 8'h00, 1,   16'h9C07, 5,   16'h0200, 16'h0201};
    vecs[6] = '{1'b0, 1'b1, 16'h0041, 8'hC5, 0,   16'h005E, 2,   16'h0041, 16'h0000};

    repeat (3) tick();
    check("rst mem_req", {31'd0, mem_req}, 0);
    check("rst mem_we", {31'd0, mem_we}, 0);
    check("rst mem_addr", {16'd0, mem_addr}, 0);
    check("rst mem_wdata", {24'd0, mem_wdata}, 0);
    check("rst acks", {30'd0, i_ack, d_ack}, 0);
    check("rst rdata", {8'd0, i_rdata, d_rdata}, 0);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("v%0d", k));
    check("mem write 0x40", {24'd0, mem[16'h0040]}, 32'h3A);
    check("mem write 0x41", {24'd0, mem[16'h0041]}, 32'hC5);

    // Contention: all requesters held from reset, each re-raised after its ack.
    reset = 1'b1; mem_wait = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
    i_req = 1'b1; i_addr = 16'h0060;
    d_drop = 1'b0; i_drop = 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
    g_req = 1'b1; g_we = 1'b0; g_addr = 16'h0050; g_drop = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    n_got = 0; multi = 0;
    for (int c = 0; c < 80 && n_got < N_ORDER; c++) begin
      tick();
      if (d_drop) begin d_req = 1'b1; d_drop = 1'b0; end
      if (i_drop) begin i_req = 1'b1; i_drop = 1'b0; end
`ifdef MEM_ARB_DBG_PORT_EN
      if (g_drop) begin g_req = 1'b1; g_drop = 1'b0; end
      if (int'(d_ack) + int'(i_ack) + int'(g_ack) > 1) multi++;
      if (g_ack) begin got_order[n_got] = 2; n_got++; g_req = 1'b0; g_drop = 1'b1; end
`else
      if (int'(d_ack) + int'(i_ack) > 1) multi++;
`endif
      if (d_ack) begin got_order[n_got] = 0; n_got++; d_req = 1'b0; d_drop = 1'b1; end
      if (i_ack && n_got < N_ORDER) begin got_order[n_got] = 1; n_got++; i_req = 1'b0; i_drop = 1'b1; end
    end
    d_req = 1'b0; i_req = 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
    g_req = 1'b0;
`endif
    check("rr grant count", n_got, N_ORDER);
    check("rr single ack", multi, 0);
    for (int k = 0; k < N_ORDER; k++)
      if (k < n_got) check($sformatf("rr order %0d", k), got_order[k], exp_order[k]);
    repeat (4) tick();

    // Reset during BEAT1 of a fetch abandons it; the held request then completes.
    mem_wait = 0; bad_ack = 0;
    tick();
    i_req = 1'b1; i_addr = 16'h0300;
    tick(); if (i_ack) bad_ack++;
    tick(); if (i_ack) bad_ack++;
    check("abort beat1 req", {31'd0, mem_req}, 1);
    check("abort beat1 addr", {16'd0, mem_addr}, 32'h0301);
    reset = 1'b1;
    tick(); if (i_ack) bad_ack++;
    check("abort mem_req low", {31'd0, mem_req}, 0);
    check("abort i_rdata cleared", {16'd0, i_rdata}, 0);
    reset = 1'b0;
    nacks = 0; ack_cyc = -1; got16 = '0;
    for (int c = 4; c < 30; c++) begin
      tick();
      if (i_ack) begin
        nacks++;
        if (ack_cyc < 0) begin ack_cyc = c; got16 = i_rdata; end
        i_req = 1'b0;
      end
      if (ack_cyc >= 0 && c >= ack_cyc + 3) break;
    end
    check("abort no ack", bad_ack, 0);
    check("retry ack count", nacks, 1);
    check("retry ack cycle", ack_cyc, 6);
    check("retry rdata", {16'd0, got16}, 32'h1122);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
